// File: rtl/wb_burst_slave.sv
// wb_burst_slave: Wishbone B3 RAM responder with wait states,
// CTI/BTE bursts and error termination for out-of-range words.
module wb_burst_slave #(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o
);
   localparam int            IW      = $clog2(DEPTH);
   localparam logic [AW-2:0] DEPTH_W = (AW-1)'(DEPTH);
   localparam logic [AW-2:0] ONE_W   = (AW-1)'(1);
   localparam logic [3:0]    WS      = 4'(WAIT_STATES);
   localparam logic [2:0]    CTI_CLS = 3'b000;
   localparam logic [2:0]    CTI_INC = 3'b010;
   localparam logic [2:0]    CTI_END = 3'b111;

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_ack, r_err, w_ack_nxt, w_err_nxt;
   logic [DW-1:0] r_dat;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [IW-1:0] r_adr, w_adr_nxt, w_idx, w_inc, w_mask, w_rd_idx;
   logic [2:0]    r_cti, w_cti_nxt;
   logic [1:0]    r_bte, w_bte_nxt;
   logic          w_rd, w_wr, w_oor, w_oor_nxt, w_last;
   logic [AW-2:0] w_word;
   logic          w_unused;
   logic [DW-1:0] r_mem [DEPTH];

   assign w_unused  = &{1'b0, wb_adr_i[1:0]};
   assign w_idx     = wb_adr_i[2 +: IW];
   assign w_word    = {1'b0, wb_adr_i[AW-1:2]};
   assign w_oor     = w_word >= DEPTH_W;
   // A pre-acked linear beat is checked against the master's next word.
   assign w_oor_nxt = (r_bte == 2'b00) ? ((w_word + ONE_W) >= DEPTH_W)
                                       : w_oor;
   assign w_last    = (wb_cti_i == CTI_END) || (wb_cti_i == CTI_CLS);
   assign w_wr      = r_ack & wb_cyc_i & wb_stb_i & wb_we_i;

   always_comb begin
      w_mask = '1;
      unique case (r_bte)
         2'b01:   w_mask = IW'(3);
         2'b10:   w_mask = IW'(7);
         2'b11:   w_mask = IW'(15);
         default: w_mask = '1;
      endcase
   end

   assign w_inc = (r_adr & ~w_mask) | ((r_adr + IW'(1)) & w_mask);

   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_adr_nxt   = r_adr;
      w_cti_nxt   = r_cti;
      w_bte_nxt   = r_bte;
      w_rd        = 1'b0;
      w_rd_idx    = r_adr;
      if (!wb_cyc_i) begin
         w_state_nxt = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (wb_stb_i && !r_ack && !r_err) begin
                  w_adr_nxt = w_idx;
                  w_cti_nxt = wb_cti_i;
                  w_bte_nxt = wb_bte_i;
                  w_cnt_nxt = WS;
                  if (WAIT_STATES == 0) begin
                     w_rd     = 1'b1;
                     w_rd_idx = w_idx;
                     if (w_oor) begin
                        w_err_nxt = 1'b1;
                     end else begin
                        w_ack_nxt = 1'b1;
                        if (wb_cti_i == CTI_INC) w_state_nxt = BURST;
                     end
                  end else begin
                     w_state_nxt = WAIT;
                  end
               end
            end
            WAIT: begin
               if (r_cnt > 4'd1) begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end else begin
                  w_cnt_nxt   = 4'd0;
                  w_rd        = 1'b1;
                  w_state_nxt = IDLE;
                  if (w_oor) begin
                     w_err_nxt = 1'b1;
                  end else begin
                     w_ack_nxt = 1'b1;
                     if (r_cti == CTI_INC) w_state_nxt = BURST;
                  end
               end
            end
            BURST: begin
               if (wb_stb_i) begin
                  if (r_ack) begin
                     if (w_last) begin
                        w_state_nxt = IDLE;
                     end else if (w_oor_nxt) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                     end else begin
                        w_ack_nxt = 1'b1;
                        w_adr_nxt = w_inc;
                        w_rd      = 1'b1;
                        w_rd_idx  = w_inc;
                     end
                  end else if (w_oor) begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = IDLE;
                  end else begin
                     w_ack_nxt = 1'b1;
                     w_rd      = 1'b1;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
         r_cnt   <= 4'd0;
         r_adr   <= '0;
         r_cti   <= CTI_CLS;
         r_bte   <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_cnt   <= w_cnt_nxt;
         r_adr   <= w_adr_nxt;
         r_cti   <= w_cti_nxt;
         r_bte   <= w_bte_nxt;
         if (w_rd) r_dat <= r_mem[w_rd_idx];
      end
   end

   // The write commits at the end of the ack cycle, addressed by r_adr.
   always_ff @(posedge wb_clk_i) begin
      if (w_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) r_mem[r_adr][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
endmodule
